// File: rtl/fetch_stage_pkg.sv
// Shared widths and state encoding for the instruction fetch stage.
package fetch_stage_pkg;

  localparam int FETCH_INSTR_W = 64;
  localparam int FETCH_ADDR_W  = 10;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a memory read that returns while decode is stalled.
module fetch_skid_buffer
  import fetch_stage_pkg::*;
#(
  parameter int DW = FETCH_INSTR_W,
  parameter int AW = FETCH_ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          load_i,
  input  logic          unload_i,
  input  logic [DW-1:0] data_i,
  input  logic [AW-1:0] pc_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [AW-1:0] pc_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic [AW-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      pc_q    <= pc_i;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: walks PC over a 1-cycle synchronous IMEM, with stall skid and redirect.
// Define FETCH_PERF_CNT_EN to add the stall_cycles / redirect_cnt performance counters.
//
// state       | meaning
// FETCH_IDLE  | waiting for start
// FETCH_RUN   | issuing reads while pc < len
// FETCH_DRAIN | no more reads; waiting for the last instruction to leave
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int INSTR_WIDTH     = FETCH_INSTR_W,
  parameter int IMEM_ADDR_WIDTH = FETCH_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [IMEM_ADDR_WIDTH-1:0] prog_len,
  input  logic                       fetch_stall,
  input  logic                       redirect_valid,
  input  logic [IMEM_ADDR_WIDTH-1:0] redirect_pc,
  output logic                       imem_en,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [INSTR_WIDTH-1:0]     imem_rdata,
  output logic [INSTR_WIDTH-1:0]     instr,
  output logic [IMEM_ADDR_WIDTH-1:0] instr_pc,
  output logic                       instr_valid,
  output logic                       busy,
  output logic                       done
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                stall_cycles,
  output logic [31:0]                redirect_cnt
`endif
);

  localparam int AW = IMEM_ADDR_WIDTH;

  fetch_state_e     state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [AW-1:0]    len_q, len_d;
  logic             inflight_q, inflight_d;
  logic [AW-1:0]    inflight_pc_q, inflight_pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [AW-1:0]    instr_pc_q, instr_pc_d;
  logic             instr_valid_q, instr_valid_d;
  logic             done_q, done_d;

  logic             fetch_go;
  logic             skid_load, skid_unload, skid_flush;
  logic             skid_valid;
  logic [INSTR_WIDTH-1:0] skid_data;
  logic [AW-1:0]    skid_pc;

  fetch_skid_buffer #(
    .DW (INSTR_WIDTH),
    .AW (AW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (skid_flush),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .data_i   (imem_rdata),
    .pc_i     (inflight_pc_q),
    .valid_o  (skid_valid),
    .data_o   (skid_data),
    .pc_o     (skid_pc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    len_d         = len_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    done_d        = 1'b0;
    skid_load     = 1'b0;
    skid_unload   = 1'b0;
    skid_flush    = 1'b0;

    fetch_go = (state_q == FETCH_RUN) && !fetch_stall && !redirect_valid && (pc_q < len_q);

    if (fetch_go) begin
      pc_d          = pc_q + AW'(1);
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end

    // Skid and in-flight can never both be occupied on a non-stalled cycle.
    if (fetch_stall) begin
      skid_load = inflight_q;
    end else if (skid_valid) begin
      instr_d       = skid_data;
      instr_pc_d    = skid_pc;
      instr_valid_d = 1'b1;
      skid_unload   = 1'b1;
    end else if (inflight_q) begin
      instr_d       = imem_rdata;
      instr_pc_d    = inflight_pc_q;
      instr_valid_d = 1'b1;
    end else begin
      instr_valid_d = 1'b0;
    end

    case (state_q)
      FETCH_IDLE: begin
        if (start) begin
          pc_d    = '0;
          len_d   = prog_len;
          state_d = (prog_len == '0) ? FETCH_DRAIN : FETCH_RUN;
        end
      end
      FETCH_RUN: begin
        if (!fetch_go && (pc_q == len_q)) state_d = FETCH_DRAIN;
      end
      FETCH_DRAIN: begin
        if (!inflight_q && !skid_valid && (!instr_valid_q || !fetch_stall)) begin
          state_d = FETCH_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase

    // Redirect overrides stall and drain; the read still in flight is dropped.
    if (redirect_valid && (state_q != FETCH_IDLE)) begin
      pc_d          = redirect_pc;
      inflight_d    = 1'b0;
      skid_flush    = 1'b1;
      skid_load     = 1'b0;
      skid_unload   = 1'b0;
      instr_valid_d = 1'b0;
      done_d        = 1'b0;
      state_d       = (redirect_pc >= len_q) ? FETCH_DRAIN : FETCH_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH_IDLE;
      pc_q          <= '0;
      len_q         <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      len_q         <= len_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      done_q        <= done_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        start_acc, redir_acc;
  logic [31:0] stall_cnt_q, redir_cnt_q;

  assign start_acc = (state_q == FETCH_IDLE) && start;
  assign redir_acc = (state_q != FETCH_IDLE) && redirect_valid;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (fetch_stall && instr_valid_q) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redir_acc)                    redir_cnt_q <= redir_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign redirect_cnt = redir_cnt_q;
`endif

  assign imem_en     = fetch_go;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign busy        = (state_q != FETCH_IDLE);
  assign done        = done_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage sitting directly upstream of the decode stage.
- Walks the program counter over a synchronous instruction memory (1-cycle read latency) and presents `instr` / `instr_pc` / `instr_valid` to decode.
- Honours a downstream stall, handles branch/jump redirects from the execute stage, and stops at the program length.
- Contains a 1-entry skid buffer so that stalls cause no lost or duplicated instructions.

Parameters:
- INSTR_WIDTH, 64, instruction word width (4 x 16-bit DDR slots).
- IMEM_ADDR_WIDTH, 10, instruction memory address / PC width.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  one-cycle pulse; begin fetching at PC 0 (sampled only in IDLE).
- prog_len  in  IMEM_ADDR_WIDTH  number of valid instructions; sampled on start.
- fetch_stall  in  1  downstream cannot accept; outputs must hold.
- redirect_valid  in  1  execute-stage branch/jump taken.
- redirect_pc  in  IMEM_ADDR_WIDTH  redirect target.
- imem_en  out  1  instruction memory read enable.
- imem_addr  out  IMEM_ADDR_WIDTH  read address (= pc_r).
- imem_rdata  in  INSTR_WIDTH  read data, valid the cycle after imem_en.
- instr  out  INSTR_WIDTH  fetched instruction to decode.
- instr_pc  out  IMEM_ADDR_WIDTH  PC of `instr`.
- instr_valid  out  1  `instr` valid.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on return to IDLE.

Behaviour:
- States: IDLE, RUN, DRAIN. Reset puts the block in IDLE with:
  - pc_r=0, inflight=0, skid_valid=0;
  - instr=0, instr_pc=0, instr_valid=0;
  - imem_en=0, busy=0, done=0.
- IDLE, start=1: pc_r<=0, len_r<=prog_len, go RUN. If prog_len==0, go to DRAIN instead (done pulses next cycle, no fetch).
- imem_en (combinational) = (state==RUN) && !fetch_stall && !redirect_valid && pc_r<len_r.
  - When imem_en: pc_r<=pc_r+1, inflight<=1, inflight_pc<=pc_r. Otherwise inflight<=0.
- Latency: start at edge E0 -> imem_en high in the cycle after E0 -> instr_valid with instr_pc=0 after edge E2. Steady state: one instruction per cycle.
- Output register, no stall: when inflight, {instr, instr_pc, instr_valid} <= {imem_rdata, inflight_pc, 1}; else instr_valid<=0.
- Output register, fetch_stall=1:
  - Outputs hold.
  - A returning read (inflight) is written to the skid entry. At most one can arrive, because imem_en is already low.
- Stall release: outputs <= skid entry if skid_valid, and skid is cleared. A fetch may be issued in the same cycle, so there is no bubble and no duplicate.
- Redirect (priority over stall and over everything except rst):
  - pc_r<=redirect_pc, inflight<=0, skid_valid<=0, instr_valid<=0.
  - The in-flight rdata is discarded.
  - Accepted in RUN and DRAIN, going to RUN. Ignored in IDLE.
  - A target >= len_r results in DRAIN.
- RUN -> DRAIN when pc_r==len_r and no fetch is issued.
- DRAIN -> IDLE when inflight=0, skid_valid=0 and (instr_valid=0 or fetch_stall=0). `done` pulses for one cycle on that transition.
- pc_r arithmetic is IMEM_ADDR_WIDTH wide and wraps modulo 2^IMEM_ADDR_WIDTH. Wrap is unreachable while pc_r < len_r.
- start outside IDLE is ignored.
- rst mid-operation: everything returns to reset values on the next edge. Stale rdata is never presented.

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds two outputs, each 32-bit and cleared on start and on rst:
  - stall_cycles: increments each cycle where fetch_stall && instr_valid.
  - redirect_cnt: increments per accepted redirect.
- Undefined: these ports and counters do not exist. Functional behaviour is identical either way.

Decomposition:
- Shared header (parameters.vh / encoding.vh): IMEM_ADDR_WIDTH, INSTR_WIDTH, and the FETCH_IDLE/RUN/DRAIN state encodings.
- Sub-module `fetch_skid_buffer`: 1-entry {data, pc, valid} register with load/unload/flush.

Test Plan:
- prog_len=4, imem[i]=i+0x100, no stall: instr_valid after edge E2, PCs 0,1,2,3 on consecutive cycles, done pulses once, busy low after.
- Same program, fetch_stall high for 3 cycles while instr_pc=1: instr_pc=1 held, then 2,3 follow. No loss, no duplicate, skid used exactly once.
- prog_len=8, redirect_valid with redirect_pc=6 while instr_pc=2: PC 3 never appears valid, next valid instr_pc=6, then 7, then done.
- redirect and fetch_stall asserted in the same cycle: instr_valid=0 next cycle, and the next valid PC is the target after stall release.
- rst asserted mid-RUN at PC 5: the next cycle has all outputs 0 and state IDLE. A new start refetches from PC 0.
- prog_len=0: done pulses, instr_valid never high, imem_en never high. With FETCH_PERF_CNT_EN, the stall scenario gives stall_cycles=3.
